endec_axis_host: RTL and testbench
==================================

# endec_axis_host

Host-side AXI4-Stream endpoint for `endec_interface`. It latches one job (code configuration, 128-bit encoder frame, 384-bit decoder frame) and serializes it into 64-bit beats on a master stream. It then collects the 512-bit result from the slave stream and presents it as parallel `o_encoder_data` / `o_decoder_data`. It sits between the processor-facing register bank and the endec core.

## Interface
Parameters:
- `DATA_W`, 64: stream beat width; fixed, other values unsupported.
- `TX_BEATS`, 9: beats sent per job (1 config + 8 data).
- `RX_BEATS`, 8: beats received per job.

Ports:
- `sys_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  job request pulse; sampled only in IDLE.
- `i_code_rate`  in  1  `CODE_RATE_2`/`CODE_RATE_3` select.
- `i_gen_poly_flat`  in  27  generator polynomials, poly k at [9k+8:9k].
- `i_encoder_data_frame`  in  128  message bits to encode.
- `i_decoder_data_frame`  in  384  coded bits to decode.
- `m_axis_tdata`  out  64;  `m_axis_tvalid`  out  1;  `m_axis_tlast`  out  1;  `m_axis_tready`  in  1.
- `s_axis_tdata`  in  64;  `s_axis_tvalid`  in  1;  `s_axis_tlast`  in  1;  `s_axis_tready`  out  1.
- `o_encoder_data`  out  384  encoded result.
- `o_decoder_data`  out  128  decoded result.
- `o_busy`  out  1  high from the start-accept cycle until DONE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_frame_error`  out  1  RX framing error flag; sticky until next accepted `i_start`.

## Operation
- TX image (576 b), sent MSB beat first:
  - config word = {36'b0, `i_code_rate`, `i_gen_poly_flat`};
  - then `i_decoder_data_frame` (6 beats);
  - then `i_encoder_data_frame` (2 beats).
- `m_axis_tlast` = 1 on beat 0 (config is its own packet) and on beat 8.
- RX image (512 b), MSB beat first:
  - beats 0–1 → `o_decoder_data[127:0]`;
  - beats 2–7 → `o_encoder_data[383:0]`.
- FSM states and transitions:
  - IDLE: `i_start` → latch all inputs into a 576-bit TX shift register; clear `o_frame_error` and the RX accumulator; go to SEND_CFG.
  - SEND_CFG: on handshake, go to SEND_DATA.
  - SEND_DATA: on the 8th data handshake, go to RECV.
  - RECV: on the receive-end condition below, go to DONE.
  - DONE: pulse `o_done`; go to IDLE.
- `s_axis_tready` = 1 in SEND_CFG, SEND_DATA and RECV. Beats accepted before RECV are stored normally; the RX counter runs independently of TX.
- Receive ends on whichever comes first: `s_axis_tlast` accepted, or beat 7 accepted.
  - `s_axis_tlast` on beat < 7: set `o_frame_error`; unreceived bits read 0.
  - Beat 7 accepted without `s_axis_tlast`: set `o_frame_error`; further beats are not accepted.
- Results update only in DONE. Results hold until the next DONE; reset clears them.
- `i_start` while not IDLE is ignored. Input changes after the start cycle have no effect.

## Timing
- Reset value of every output is 0, including `s_axis_tready`. Reset mid-job returns the FSM to IDLE on the next edge and may drop `m_axis_tvalid` without a handshake.
- All outputs are registered.
- `i_start` at edge N → `m_axis_tvalid` = 1 with the config beat from N+1.
- Once `m_axis_tvalid` is asserted, `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` hold until the handshake (`tvalid & tready`).
- Back-to-back beats with `tready` held high: TX occupies 9 consecutive cycles.
- The last RX handshake at edge M → `o_done` and valid results at M+1. `o_busy` falls at M+2.
- Beat counters are 4-bit and are never allowed to wrap.

## Structure
- Package `endec_axis_pkg` (alongside `param_def.sv` macros) holds:
  - `TX_BEATS`, `RX_BEATS`, `CFG_RATE_BIT` (27);
  - the FSM `typedef enum` {IDLE, SEND_CFG, SEND_DATA, RECV, DONE};
  - a packed struct for the config word.
- One sub-module: `endec_axis_collector`. It holds the RX beat counter, the 512-bit accumulator, and tlast checking. It outputs `rx_end` and `rx_err`.

## Test plan
- Code rate 3, polys 557/663/711 (octal), `i_code_rate`=1, tready always 1 → beat 0 = 64'h0000_0000_0C9F_37ED with tlast=1; beats 1–8 match the TX image; tlast on beat 8 only.
- Loopback model returning 512'hA5…A5 with tlast on beat 7 → `o_done` once; `o_decoder_data` = 128'hA5…; `o_encoder_data` = 384'hA5…; `o_frame_error` = 0.
- Random `m_axis_tready` (50 %) → tdata, tvalid and tlast stay stable while stalled; all 9 beats arrive in order.
- Responder asserts tlast on RX beat 3 → `o_frame_error` = 1; `o_done` pulses; `o_encoder_data[255:0]` = 0.
- `rst` asserted mid-SEND_DATA, then a new job → all outputs 0 the cycle after reset; the new job restarts with the config beat.
- `i_start` pulsed during RECV → ignored; exactly one `o_done` per accepted start.

Source files
------------

// File: rtl/endec_axis_pkg.sv
// Shared constants, FSM state type and config-word layout for the endec AXI4-Stream host.
package endec_axis_pkg;

    localparam int unsigned TX_BEATS     = 9;
    localparam int unsigned RX_BEATS     = 8;
    localparam int unsigned CFG_RATE_BIT = 27;
    localparam int unsigned BEAT_W       = 64;
    localparam int unsigned POLY_W       = 27;
    localparam int unsigned ENC_W        = 128;
    localparam int unsigned DEC_W        = 384;
    localparam int unsigned TX_W         = TX_BEATS * BEAT_W;
    localparam int unsigned RX_W         = RX_BEATS * BEAT_W;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CFG,
        SEND_DATA,
        RECV,
        DONE
    } state_e;

    typedef struct packed {
        logic [BEAT_W-POLY_W-2:0] rsvd;
        logic                     code_rate;
        logic [POLY_W-1:0]        gen_poly;
    } cfg_word_t;

endpackage

// File: rtl/endec_axis_collector.sv
// RX side: counts accepted beats, packs them MSB-first into the result image and checks tlast.
// Outputs are combinational look-ahead so the host can close the job on the accepting edge.
module endec_axis_collector
    import endec_axis_pkg::*;
#(
    parameter int unsigned RX_BEATS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              beat_i,
    input  logic              last_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic              rx_end_o,
    output logic              rx_err_o,
    output logic [RX_W-1:0]   rx_data_o
);

    logic [3:0]      cnt_q;
    logic [RX_W-1:0] acc_q;
    logic            done_q;
    logic            final_beat;
    logic            end_now;

    assign final_beat = (cnt_q == 4'(RX_BEATS - 1));
    assign end_now    = beat_i & (last_i | final_beat);
    assign rx_end_o   = done_q | end_now;
    // Framing is good only when tlast lands exactly on the final beat.
    assign rx_err_o   = end_now & (last_i != final_beat);

    always_comb begin
        rx_data_o = acc_q;
        for (int unsigned b = 0; b < RX_BEATS; b++) begin
            if (beat_i && (cnt_q == 4'(b))) begin
                rx_data_o[RX_W-1-BEAT_W*b -: BEAT_W] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
        end else if (beat_i) begin
            acc_q <= rx_data_o;
            if (end_now) begin
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/endec_axis_host.sv
// Host-side stream endpoint: serializes one endec job into 64-bit beats and collects the result.
module endec_axis_host #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TX_BEATS = 9,
    parameter int unsigned RX_BEATS = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_code_rate,
    input  logic [26:0]       i_gen_poly_flat,
    input  logic [127:0]      i_encoder_data_frame,
    input  logic [383:0]      i_decoder_data_frame,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [383:0]      o_encoder_data,
    output logic [127:0]      o_decoder_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_error
);
    import endec_axis_pkg::*;

    state_e          state_q;
    logic [TX_W-1:0] tx_q;
    logic [3:0]      tx_cnt_q;
    cfg_word_t       cfg;
    logic            tx_hs;
    logic            rx_beat;
    logic            start_acc;
    logic            rx_active;
    logic            rx_end;
    logic            rx_err;
    logic [RX_W-1:0] rx_data;

    assign cfg       = '{rsvd: '0, code_rate: i_code_rate, gen_poly: i_gen_poly_flat};
    assign tx_hs     = m_axis_tvalid & m_axis_tready;
    assign rx_beat   = s_axis_tvalid & s_axis_tready;
    assign start_acc = (state_q == IDLE) & i_start;
    assign rx_active = (state_q == SEND_CFG) | (state_q == SEND_DATA) | (state_q == RECV);

    endec_axis_collector #(
        .RX_BEATS (RX_BEATS)
    ) u_collector (
        .clk_i     (sys_clk),
        .rst_i     (rst),
        .clr_i     (start_acc),
        .beat_i    (rx_beat),
        .last_i    (s_axis_tlast),
        .data_i    (s_axis_tdata),
        .rx_end_o  (rx_end),
        .rx_err_o  (rx_err),
        .rx_data_o (rx_data)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tx_q           <= '0;
            tx_cnt_q       <= '0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            s_axis_tready  <= 1'b0;
            o_encoder_data <= '0;
            o_decoder_data <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_frame_error  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (rx_err) begin
                o_frame_error <= 1'b1;
            end
            // Once RX has ended, stop accepting even if TX is still running.
            if (rx_active && rx_end) begin
                s_axis_tready <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        tx_q          <= {cfg, i_decoder_data_frame, i_encoder_data_frame};
                        m_axis_tdata  <= cfg;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        tx_cnt_q      <= '0;
                        s_axis_tready <= 1'b1;
                        o_busy        <= 1'b1;
                        o_frame_error <= 1'b0;
                        state_q       <= SEND_CFG;
                    end
                end
                SEND_CFG, SEND_DATA: begin
                    if (tx_hs) begin
                        tx_q         <= tx_q << BEAT_W;
                        m_axis_tdata <= tx_q[TX_W-BEAT_W-1 -: BEAT_W];
                        m_axis_tlast <= (tx_cnt_q == 4'(TX_BEATS - 2));
                        tx_cnt_q     <= tx_cnt_q + 4'd1;
                        state_q      <= SEND_DATA;
                        if (tx_cnt_q == 4'(TX_BEATS - 1)) begin
                            m_axis_tdata  <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            state_q       <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (rx_end) begin
                        o_decoder_data <= rx_data[RX_W-1 -: ENC_W];
                        o_encoder_data <= rx_data[DEC_W-1:0];
                        o_done         <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    o_busy  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_endec_axis_host.sv
// Randomized scoreboard bench for endec_axis_host with a stream-level reference model.
module tb_endec_axis_host;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_code_rate;
    logic [26:0]   i_gen_poly_flat;
    logic [127:0]  i_encoder_data_frame;
    logic [383:0]  i_decoder_data_frame;
    logic [63:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [383:0]  o_encoder_data;
    logic [127:0]  o_decoder_data;
    logic          o_busy;
    logic          o_done;
    logic          o_frame_error;

    endec_axis_host #(.DATA_W(64), .TX_BEATS(9), .RX_BEATS(8)) dut (
        .sys_clk              (sys_clk),
        .rst                  (rst),
        .i_start              (i_start),
        .i_code_rate          (i_code_rate),
        .i_gen_poly_flat      (i_gen_poly_flat),
        .i_encoder_data_frame (i_encoder_data_frame),
        .i_decoder_data_frame (i_decoder_data_frame),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tready        (m_axis_tready),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .o_encoder_data       (o_encoder_data),
        .o_decoder_data       (o_decoder_data),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_frame_error        (o_frame_error)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed { logic [63:0] data; logic last; } tx_beat_t;
    typedef struct packed { logic [127:0] dec; logic [383:0] enc; logic err; } res_t;

    tx_beat_t tx_exp[$];
    res_t     res_exp[$];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    bit          tready_rand = 1'b0;
    bit          rx_active   = 1'b0;
    bit          rx_hold     = 1'b0;
    bit          rx_hs_seen  = 1'b0;
    int          rx_idx      = 0;
    int          rx_len      = 0;
    int          rx_last_at  = 0;
    logic [63:0] rx_beats [8];
    logic [63:0] rx_extra;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // TX monitor: compares accepted beats and checks stability while stalled.
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    tx_beat_t    tx_got;
    always @(negedge sys_clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", m_axis_tvalid, 1'b1);
                check("tx_hold_data", m_axis_tdata, prev_data);
                check("tx_hold_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (tx_exp.size() == 0) begin
                    fail_event("tx_unexpected_beat");
                end else begin
                    tx_got = tx_exp.pop_front();
                    check("tx_data", m_axis_tdata, tx_got.data);
                    check("tx_last", m_axis_tlast, tx_got.last);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    // Result monitor: pops the expected result on every o_done.
    bit   chk_after_done = 1'b0;
    res_t res_got;
    always @(negedge sys_clk) begin
        if (rst) begin
            chk_after_done = 1'b0;
            rx_hs_seen     = 1'b0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) rx_hs_seen = 1'b1;
            if (chk_after_done) begin
                check("busy_fall", o_busy, 1'b0);
                check("done_pulse_width", o_done, 1'b0);
                chk_after_done = 1'b0;
            end
            if (o_done) begin
                done_cnt++;
                if (res_exp.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    res_got = res_exp.pop_front();
                    check("res_dec", o_decoder_data, res_got.dec);
                    check("res_enc", o_encoder_data, res_got.enc);
                    check("res_frame_error", o_frame_error, res_got.err);
                    check("busy_at_done", o_busy, 1'b1);
                end
                chk_after_done = 1'b1;
            end
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // RX responder: offers planned beats with random gaps, holding each until accepted.
    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (rx_hs_seen) begin
                rx_idx++;
                rx_hs_seen    = 1'b0;
                s_axis_tvalid = 1'b0;
            end
            if (!rx_active) begin
                s_axis_tvalid = 1'b0;
            end else if (!s_axis_tvalid && !rx_hold && rx_idx < rx_len && $urandom_range(0, 3) != 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = (rx_idx < 8) ? rx_beats[rx_idx] : rx_extra;
                s_axis_tlast  = (rx_idx == rx_last_at);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"}, m_axis_tdata, '0);
        check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        check({tag, "_tlast"}, m_axis_tlast, 1'b0);
        check({tag, "_s_tready"}, s_axis_tready, 1'b0);
        check({tag, "_enc"}, o_encoder_data, '0);
        check({tag, "_dec"}, o_decoder_data, '0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_ferr"}, o_frame_error, 1'b0);
    endtask

    task automatic randomize_inputs();
        i_code_rate          = 1'($urandom_range(0, 1));
        i_gen_poly_flat      = 27'($urandom);
        i_encoder_data_frame = {$urandom, $urandom, $urandom, $urandom};
        for (int w = 0; w < 12; w++) i_decoder_data_frame = {i_decoder_data_frame[351:0], 32'($urandom)};
    endtask

    // Builds the expected TX beat list and issues the start pulse.
    task automatic start_job(input bit rate, input logic [26:0] poly,
                             input logic [127:0] enc, input logic [383:0] dec);
        logic [575:0] img;
        img = {36'b0, rate, poly, dec, enc};
        for (int k = 0; k < 9; k++) begin
            tx_exp.push_back({img[575:512], (k == 0 || k == 8)});
            img = img << 64;
        end
        @(posedge sys_clk); #1;
        i_code_rate          = rate;
        i_gen_poly_flat      = poly;
        i_encoder_data_frame = enc;
        i_decoder_data_frame = dec;
        i_start              = 1'b1;
        @(posedge sys_clk); #1;
        i_start = 1'b0;
        check("start_tvalid", m_axis_tvalid, 1'b1);
        check("start_tlast", m_axis_tlast, 1'b1);
        check("start_cfg_beat", m_axis_tdata, {36'b0, rate, poly});
        check("start_busy", o_busy, 1'b1);
        check("start_ferr_clear", o_frame_error, 1'b0);
        randomize_inputs();
    endtask

    task automatic run_job(input bit rate, input logic [26:0] poly, input logic [127:0] enc,
                           input logic [383:0] dec, input int last_at, input bit rand_ready,
                           input bit start_in_recv, input bit all_a5);
        logic [511:0] img;
        res_t         r;
        int           acc;
        int           cyc;
        int           done_before;
        tready_rand = rand_ready;
        for (int k = 0; k < 8; k++) rx_beats[k] = all_a5 ? {8{8'hA5}} : {$urandom, $urandom};
        rx_extra = {$urandom, $urandom};
        acc = (last_at < 8) ? last_at + 1 : 8;
        img = '0;
        for (int k = 0; k < 8; k++) img = {img[447:0], (k < acc) ? rx_beats[k] : 64'h0};
        r.dec = img[511:384];
        r.enc = img[383:0];
        r.err = (last_at != 7);
        res_exp.push_back(r);
        rx_last_at  = last_at;
        rx_len      = (last_at < 8) ? last_at + 1 : 9;
        rx_idx      = 0;
        rx_hold     = start_in_recv;
        rx_active   = 1'b1;
        done_before = done_cnt;
        start_job(rate, poly, enc, dec);
        cyc = 0;
        while (tx_exp.size() > 0 && cyc < 1000) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check("tx_all_beats_sent", tx_exp.size(), 0);
        if (!rand_ready) check("tx_back_to_back_cycles", cyc, 9);
        if (start_in_recv) begin
            repeat (3) @(posedge sys_clk);
            #1;
            i_start = 1'b1;
            @(posedge sys_clk); #1;
            i_start = 1'b0;
            rx_hold = 1'b0;
        end
        cyc = 0;
        while (done_cnt == done_before && cyc < 2000) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        rx_active = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        check("one_done_per_start", done_cnt, done_before + 1);
        check("idle_after_job_busy", o_busy, 1'b0);
        check("idle_after_job_tvalid", m_axis_tvalid, 1'b0);
        tx_exp.delete();
        res_exp.delete();
    endtask

    task automatic reset_mid_job();
        int cyc;
        tready_rand = 1'b0;
        rx_active   = 1'b0;
        randomize_inputs();
        start_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame);
        cyc = 0;
        while (tx_exp.size() > 5 && cyc < 100) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check("reached_send_data", m_axis_tvalid, 1'b1);
        rst = 1'b1;
        @(posedge sys_clk); #1;
        check_all_zero("mid_reset");
        rst = 1'b0;
        tx_exp.delete();
        res_exp.delete();
        rx_idx     = 0;
        rx_hs_seen = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        randomize_inputs();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Rate 3 with bit-reversed 557/663/711, loopback of all-A5.
        run_job(1'b1, 27'h49F37ED, {$urandom, $urandom, $urandom, $urandom},
                {12{$urandom}}, 7, 1'b0, 1'b0, 1'b1);
        check("a5_dec", o_decoder_data, {16{8'hA5}});
        check("a5_enc", o_encoder_data, {48{8'hA5}});
        check("a5_ferr", o_frame_error, 1'b0);

        for (int j = 0; j < 4; j++) begin
            randomize_inputs();
            run_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame,
                    7, 1'b1, 1'b0, 1'b0);
        end

        randomize_inputs();
        run_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame,
                3, 1'b1, 1'b0, 1'b0);
        check("early_tlast_ferr", o_frame_error, 1'b1);
        check("early_tlast_enc_low_zero", o_encoder_data[255:0], '0);

        randomize_inputs();
        run_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame,
                99, 1'b1, 1'b0, 1'b0);
        check("missing_tlast_ferr", o_frame_error, 1'b1);

        reset_mid_job();

        randomize_inputs();
        run_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame,
                7, 1'b0, 1'b0, 1'b0);

        randomize_inputs();
        run_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame,
                7, 1'b1, 1'b1, 1'b0);

        randomize_inputs();
        run_job(i_code_rate, i_gen_poly_flat, i_encoder_data_frame, i_decoder_data_frame,
                7, 1'b1, 1'b0, 1'b0);
        check("final_ferr_clear", o_frame_error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
